// File: rtl/alu_display_pkg.sv
// alu_display_pkg: shared types for the ALU result display.
// FSM states, seven-segment codes, double-dabble helpers.
package alu_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // add-3 correction applied before each shift
  function automatic logic [BCD_W-1:0] dd_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_output_display_if.sv
// alu_output_display_if: start/busy/done link to the BCD engine.
// master: start, din out; slave: load, busy, done, bcd out.
interface alu_output_display_if #(
  parameter int N_DATA = 8
);
  import alu_display_pkg::*;

  logic              start;
  logic [N_DATA-1:0] din;
  logic              load;
  logic              busy;
  logic              done;
  logic [BCD_W-1:0]  bcd;

  modport master (
    output start, din,
    input  load, busy, done, bcd
  );

  modport slave (
    input  start, din,
    output load, busy, done, bcd
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle.
// i_clock, i_reset_n, cv (slave): start/din in, load/busy/done/bcd out.
module bin2bcd_seq
  import alu_display_pkg::*;
#(
  parameter int N_DATA = 8
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  alu_output_display_if.slave  cv
);

  localparam int CW = $clog2(N_DATA);

  state_t            state_q;
  state_t            state_d;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic [N_DATA-1:0] mag_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  assign adj = dd_adj(bcd_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cv.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(N_DATA-1))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_LOAD: begin
          mag_q  <= cv.din;
          bcd_q  <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
        end
        S_SHIFT: begin
          bcd_q <= {adj[BCD_W-2:0], mag_q[N_DATA-1]};
          mag_q <= {mag_q[N_DATA-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE:  busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cv.load = (state_q == S_LOAD);
  assign cv.done = (state_q == S_DONE);
  assign cv.busy = busy_q;
  assign cv.bcd  = bcd_q;

endmodule

// File: rtl/alu_output_display.sv
// alu_output_display: ALU result to 4-digit 7-seg + LEDs.
// i_clock, i_reset_n, i_alu_result in; o_led, o_seg, o_an, o_busy out.
module alu_output_display
  import alu_display_pkg::*;
#(
  parameter int N_DATA      = 8,
  parameter bit SIGNED      = 1'b1,
  parameter int REFRESH_CNT = 100000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [N_DATA-1:0] i_alu_result,
  output logic [N_DATA-1:0] o_led,
  output logic [6:0]        o_seg,
  output logic [3:0]        o_an,
  output logic              o_busy
);

  localparam int RW = $clog2(REFRESH_CNT);

  alu_output_display_if #(.N_DATA(N_DATA)) cv ();

  logic [N_DATA-1:0] captured;
  logic [3:0]        hund_q, tens_q, units_q;
  logic              neg_q, blank_h_q, blank_t_q;
  logic [RW-1:0]     ref_q;
  logic [1:0]        idx_q, idx_d;
  logic              wrap;
  logic [6:0]        seg_d;

  assign cv.start = (i_alu_result != captured);
  // -MIN stays N bits wide, so it reads as +2^(N-1)
  assign cv.din = (SIGNED && i_alu_result[N_DATA-1])
                ? -i_alu_result
                : i_alu_result;
  assign o_busy = cv.busy;

  bin2bcd_seq #(.N_DATA(N_DATA)) u_conv (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .cv        (cv)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      captured  <= '0;
      o_led     <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      neg_q     <= 1'b0;
      blank_h_q <= 1'b1;
      blank_t_q <= 1'b1;
    end else begin
      if (cv.load) begin
        captured <= i_alu_result;
        o_led    <= i_alu_result;
      end
      if (cv.done) begin
        hund_q    <= cv.bcd[11:8];
        tens_q    <= cv.bcd[7:4];
        units_q   <= cv.bcd[3:0];
        neg_q     <= SIGNED && captured[N_DATA-1];
        blank_h_q <= (cv.bcd[11:8] == 4'd0);
        blank_t_q <= (cv.bcd[11:4] == 8'd0);
      end
    end
  end

  assign wrap  = (ref_q == RW'(REFRESH_CNT-1));
  assign idx_d = wrap ? idx_q + 2'd1 : idx_q;

  // segments follow the next index so o_an/o_seg move together
  always_comb begin
    seg_d = SEG_BLANK;
    unique case (idx_d)
      2'd0: seg_d = seg7(units_q);
      2'd1: seg_d = blank_t_q ? SEG_BLANK : seg7(tens_q);
      2'd2: seg_d = blank_h_q ? SEG_BLANK : seg7(hund_q);
      2'd3: seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ref_q <= '0;
      idx_q <= 2'd0;
      o_an  <= 4'b1110;
      o_seg <= SEG_0;
    end else begin
      ref_q <= wrap ? '0 : ref_q + 1'b1;
      idx_q <= idx_d;
      o_an  <= ~(4'b0001 << idx_d);
      o_seg <= seg_d;
    end
  end

endmodule
